// File: rtl/cache_trace_sim.sv
// Replays an address trace through a direct-mapped L1 and an N-way true-LRU L2, counting hits/misses.
// Latency: 4 cycles per trace entry (FETCH/WAIT/LOOKUP/UPDATE); start is ignored while busy.
module cache_trace_sim #(
  parameter int ADDR_W   = 32,
  parameter int PTR_W    = 10,
  parameter int CNT_W    = 10,
  parameter int OFFSET_W = 2,
  parameter int L1_IDX_W = 4,
  parameter int L2_SET_W = 3,
  parameter int L2_WAYS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PTR_W-1:0]  trace_len,
  output logic              mem_rd_en,
  output logic [PTR_W-1:0]  mem_rd_addr,
  input  logic [ADDR_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              updated,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  l1_hit_count,
  output logic [CNT_W-1:0]  l2_hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int BLK_W    = ADDR_W - OFFSET_W;
  localparam int L1_TAG_W = BLK_W - L1_IDX_W;
  localparam int L2_TAG_W = BLK_W - L2_SET_W;
  localparam int L1_LINES = 1 << L1_IDX_W;
  localparam int L2_SETS  = 1 << L2_SET_W;
  localparam int AGE_W    = $clog2(L2_WAYS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LOOKUP, S_UPDATE, S_DONE} state_t;

  state_t                state_q;
  logic [PTR_W-1:0]      ptr_q, len_q;
  logic [BLK_W-1:0]      blk_q;
  logic [L1_LINES-1:0]   l1_vld_q;
  logic [L1_TAG_W-1:0]   l1_tag_q [L1_LINES];
  logic                  l2_vld_q [L2_SETS][L2_WAYS];
  logic [L2_TAG_W-1:0]   l2_tag_q [L2_SETS][L2_WAYS];
  logic [AGE_W-1:0]      l2_age_q [L2_SETS][L2_WAYS];
  logic                  l1_hit_q, l2_hit_q;
  logic [AGE_W-1:0]      way_q;

  logic [L1_IDX_W-1:0]   l1_idx;
  logic [L1_TAG_W-1:0]   l1_tag;
  logic [L2_SET_W-1:0]   l2_set;
  logic [L2_TAG_W-1:0]   l2_tag;
  logic                  l1_hit_d, l2_hit_d, vic_found;
  logic [AGE_W-1:0]      hit_way, vic_way, way_d, touch_age;
  logic [PTR_W-1:0]      ptr_inc;

  assign l1_idx    = blk_q[L1_IDX_W-1:0];
  assign l1_tag    = blk_q[BLK_W-1:L1_IDX_W];
  assign l2_set    = blk_q[L2_SET_W-1:0];
  assign l2_tag    = blk_q[BLK_W-1:L2_SET_W];
  assign touch_age = l2_age_q[l2_set][way_q];
  assign ptr_inc   = ptr_q + PTR_W'(1);

  // Victim: lowest-index invalid way, else the oldest (age == L2_WAYS-1).
  always_comb begin
    l1_hit_d  = l1_vld_q[l1_idx] && (l1_tag_q[l1_idx] == l1_tag);
    l2_hit_d  = 1'b0;
    hit_way   = '0;
    vic_way   = '0;
    vic_found = 1'b0;
    for (int w = 0; w < L2_WAYS; w++) begin
      if (l2_vld_q[l2_set][w] && (l2_tag_q[l2_set][w] == l2_tag)) begin
        l2_hit_d = 1'b1;
        hit_way  = AGE_W'(w);
      end
      if (!vic_found && !l2_vld_q[l2_set][w]) begin
        vic_found = 1'b1;
        vic_way   = AGE_W'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < L2_WAYS; w++) begin
        if (l2_age_q[l2_set][w] == AGE_W'(L2_WAYS - 1)) vic_way = AGE_W'(w);
      end
    end
    way_d = l2_hit_d ? hit_way : vic_way;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      blk_q        <= '0;
      l1_vld_q     <= '0;
      l1_hit_q     <= 1'b0;
      l2_hit_q     <= 1'b0;
      way_q        <= '0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      updated      <= 1'b0;
      access_count <= '0;
      l1_hit_count <= '0;
      l2_hit_count <= '0;
      miss_count   <= '0;
      for (int i = 0; i < L1_LINES; i++) l1_tag_q[i] <= '0;
      for (int s = 0; s < L2_SETS; s++) begin
        for (int w = 0; w < L2_WAYS; w++) begin
          l2_vld_q[s][w] <= 1'b0;
          l2_tag_q[s][w] <= '0;
          l2_age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      mem_rd_en <= 1'b0;
      updated   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            access_count <= '0;
            l1_hit_count <= '0;
            l2_hit_count <= '0;
            miss_count   <= '0;
            l1_vld_q     <= '0;
            for (int s = 0; s < L2_SETS; s++) begin
              for (int w = 0; w < L2_WAYS; w++) begin
                l2_vld_q[s][w] <= 1'b0;
                l2_age_q[s][w] <= AGE_W'(w);
              end
            end
            ptr_q <= '0;
            len_q <= trace_len;
            if (trace_len == '0) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              updated <= 1'b1;
            end else begin
              state_q     <= S_FETCH;
              busy        <= 1'b1;
              done        <= 1'b0;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= '0;
            end
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          blk_q   <= mem_rd_data[ADDR_W-1:OFFSET_W];
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          l1_hit_q <= l1_hit_d;
          l2_hit_q <= l2_hit_d;
          way_q    <= way_d;
          state_q  <= S_UPDATE;
        end
        S_UPDATE: begin
          access_count <= sat_inc(access_count);
          if (l1_hit_q) begin
            l1_hit_count <= sat_inc(l1_hit_count);
          end else begin
            l1_vld_q[l1_idx] <= 1'b1;
            l1_tag_q[l1_idx] <= l1_tag;
            if (l2_hit_q) begin
              l2_hit_count <= sat_inc(l2_hit_count);
            end else begin
              miss_count               <= sat_inc(miss_count);
              l2_vld_q[l2_set][way_q]  <= 1'b1;
              l2_tag_q[l2_set][way_q]  <= l2_tag;
            end
            for (int w = 0; w < L2_WAYS; w++) begin
              if (AGE_W'(w) == way_q)
                l2_age_q[l2_set][w] <= '0;
              else if (l2_age_q[l2_set][w] < touch_age)
                l2_age_q[l2_set][w] <= l2_age_q[l2_set][w] + AGE_W'(1);
            end
          end
          ptr_q <= ptr_inc;
          if (ptr_inc == len_q) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            updated <= 1'b1;
          end else begin
            state_q     <= S_FETCH;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= ptr_inc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_trace_sim.sv
// Directed bench for cache_trace_sim: timing, counts, saturation, restart and mid-run reset.
module tb_cache_trace_sim;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [9:0]  trace_len;
  logic        mem_rd_en, busy, done, updated;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [9:0]  access_count, l1_hit_count, l2_hit_count, miss_count;

  logic        s_start;
  logic [9:0]  s_trace_len;
  logic        s_mem_rd_en, s_busy, s_done, s_updated;
  logic [9:0]  s_mem_rd_addr;
  logic [31:0] s_mem_rd_data;
  logic [1:0]  s_access, s_l1, s_l2, s_miss;

  logic [31:0] mem  [1024];
  logic [31:0] smem [1024];

  int total = 0;
  int bad   = 0;
  int exp_addr = 0;

  cache_trace_sim dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done), .updated(updated),
    .access_count(access_count), .l1_hit_count(l1_hit_count),
    .l2_hit_count(l2_hit_count), .miss_count(miss_count)
  );

  cache_trace_sim #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .trace_len(s_trace_len),
    .mem_rd_en(s_mem_rd_en), .mem_rd_addr(s_mem_rd_addr), .mem_rd_data(s_mem_rd_data),
    .busy(s_busy), .done(s_done), .updated(s_updated),
    .access_count(s_access), .l1_hit_count(s_l1),
    .l2_hit_count(s_l2), .miss_count(s_miss)
  );

  always @(posedge clk) if (mem_rd_en)   mem_rd_data   <= mem[mem_rd_addr];
  always @(posedge clk) if (s_mem_rd_en) s_mem_rd_data <= smem[s_mem_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read strobes must walk the trace in order, one per entry.
  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) begin
      check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr));
      exp_addr++;
    end
  end

  task automatic check_counts(input int a, input int h1, input int h2, input int m);
    check("access_count", 32'(access_count), 32'(a));
    check("l1_hit_count", 32'(l1_hit_count), 32'(h1));
    check("l2_hit_count", 32'(l2_hit_count), 32'(h2));
    check("miss_count",   32'(miss_count),   32'(m));
  endtask

  task automatic run(input int n, input bit poke);
    int k;
    exp_addr  = 0;
    trace_len = 10'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (n > 0) check("busy_after_start", 32'(busy), 32'd1);
    k = 1;
    while (done !== 1'b1 && k < 400) begin
      if (poke) start = (k == 3);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check("done_latency", 32'(k), 32'(1 + 4 * n));
    check("updated_pulse", 32'(updated), 32'd1);
    check("busy_clear", 32'(busy), 32'd0);
    check("rd_count", 32'(exp_addr), 32'(n));
    @(posedge clk); #1;
    check("updated_drop", 32'(updated), 32'd0);
    check("done_hold", 32'(done), 32'd1);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; trace_len = '0;
    s_start = 1'b0; s_trace_len = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'h0;
      smem[i] = 32'h10;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_updated", 32'(updated), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    check_counts(0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Same line four times: one cold miss then L1 hits; done 17 cycles after start.
    run(4, 1'b0);
    check_counts(4, 3, 0, 1);

    // L1 conflict between 0x00/0x40 resolved by L2; a start while busy is ignored.
    mem[0] = 32'h00; mem[1] = 32'h40; mem[2] = 32'h00;
    mem[3] = 32'h40; mem[4] = 32'h00; mem[5] = 32'h40;
    run(6, 1'b1);
    check_counts(6, 0, 4, 2);

    // LRU: 0x80 must evict 0x20, not the freshly touched 0x00.
    mem[0] = 32'h00; mem[1] = 32'h20; mem[2] = 32'h40; mem[3] = 32'h60;
    mem[4] = 32'h00; mem[5] = 32'h80; mem[6] = 32'h20;
    run(7, 1'b0);
    check_counts(7, 0, 1, 6);

    // Empty trace: done next cycle, no reads, counters cleared from the previous run.
    run(0, 1'b0);
    check_counts(0, 0, 0, 0);

    // Abort during the third access, then rerun the same trace from scratch.
    exp_addr  = 0;
    trace_len = 10'd7;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_access_count", 32'(access_count), 32'd2);
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd_en", 32'(mem_rd_en), 32'd0);
    check_counts(0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run(7, 1'b0);
    check_counts(7, 0, 1, 6);

    // 2-bit counters saturate at 3 instead of wrapping.
    s_trace_len = 10'd6;
    s_start     = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    k = 1;
    while (s_done !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("sat_done_latency", 32'(k), 32'd25);
    check("sat_access", 32'(s_access), 32'd3);
    check("sat_l1", 32'(s_l1), 32'd3);
    check("sat_l2", 32'(s_l2), 32'd0);
    check("sat_miss", 32'(s_miss), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
